// File: rtl/sudoku_pkg.sv
// Shared geometry, cell/row/grid types and the board RAM word unpacker for the
// 4x4 Sudoku completion checker.
package sudoku_pkg;

  localparam int GRID_N   = 4;
  localparam int CELL_W   = 4;
  localparam int RAM_DW   = 24;
  localparam int ROW_AW   = 2;
  localparam int COL0_LSB = 12;
  localparam int COL1_LSB = 8;
  localparam int COL2_LSB = 4;
  localparam int COL3_LSB = 0;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [GRID_N-1:0] row_t;
  typedef row_t  [GRID_N-1:0] grid_t;

  // Bits [23:16] carry cell flags and are deliberately dropped here.
  function automatic row_t unpack_row(input logic [RAM_DW-1:0] word);
    row_t r;
    r[0] = word[COL0_LSB +: CELL_W];
    r[1] = word[COL1_LSB +: CELL_W];
    r[2] = word[COL2_LSB +: CELL_W];
    r[3] = word[COL3_LSB +: CELL_W];
    return r;
  endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// Combinational check of one Sudoku group (row, column or box): ok when the
// four cells hold 1, 2, 3 and 4 exactly once each.
module sudoku_group_check
  import sudoku_pkg::*;
(
  input  row_t cells_i,
  output logic ok_o
);

  logic [GRID_N-1:0] seen_s;
  logic              all_valid_s;

  // One-hot decode of each cell; empty or out-of-range digits clear all_valid_s.
  always_comb begin
    seen_s      = 4'b0000;
    all_valid_s = 1'b1;
    for (int i = 0; i < GRID_N; i++) begin
      case (cells_i[i])
        4'd1:    seen_s[0] = 1'b1;
        4'd2:    seen_s[1] = 1'b1;
        4'd3:    seen_s[2] = 1'b1;
        4'd4:    seen_s[3] = 1'b1;
        default: all_valid_s = 1'b0;
      endcase
    end
    ok_o = (seen_s == 4'b1111) && all_valid_s;
  end

endmodule

// File: rtl/sudoku_game_checker.sv
// Scans the four board RAM rows continuously into a local grid and, one cycle
// after each completed frame, registers whether the grid is a solved board.
module sudoku_game_checker
  import sudoku_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  output logic [ROW_AW-1:0] RamAddr,
  input  logic [RAM_DW-1:0] RamDat,
  output logic              gameComplete
);

  logic [ROW_AW-1:0] addr_q, addr_d;
  grid_t             grid_q, grid_d;
  logic              frame_done_q, frame_done_d;
  logic              complete_q, complete_d;

  row_t                  grp_s [3*GRID_N];
  logic [3*GRID_N-1:0]   grp_ok_s;
  logic                  board_ok_s;

  // Groups 0..3 are rows, 4..7 columns, 8..11 the 2x2 boxes in raster order.
  for (genvar g = 0; g < GRID_N; g++) begin : g_groups
    localparam int BR = (g / 2) * 2;
    localparam int BC = (g % 2) * 2;
    assign grp_s[g]          = grid_q[g];
    assign grp_s[GRID_N+g]   = {grid_q[3][g], grid_q[2][g], grid_q[1][g], grid_q[0][g]};
    assign grp_s[2*GRID_N+g] = {grid_q[BR+1][BC+1], grid_q[BR+1][BC],
                                grid_q[BR][BC+1],   grid_q[BR][BC]};
  end

  for (genvar k = 0; k < 3*GRID_N; k++) begin : g_check
    sudoku_group_check u_group_check (
      .cells_i (grp_s[k]),
      .ok_o    (grp_ok_s[k])
    );
  end

  assign board_ok_s = &grp_ok_s;

  // Next-state: advance the row pointer, capture the current row, evaluate on frame end.
  always_comb begin
    addr_d         = addr_q + 2'd1;
    grid_d         = grid_q;
    grid_d[addr_q] = unpack_row(RamDat);
    frame_done_d   = (addr_q == 2'd3);
    if (frame_done_q) begin
      complete_d = board_ok_s;
    end else begin
      complete_d = complete_q;
    end
  end

  // State registers with synchronous reset that also discards any partial frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q       <= 2'd0;
      grid_q       <= '0;
      frame_done_q <= 1'b0;
      complete_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      grid_q       <= grid_d;
      frame_done_q <= frame_done_d;
      complete_q   <= complete_d;
    end
  end

  assign RamAddr      = addr_q;
  assign gameComplete = complete_q;

endmodule

// File: tb/tb_sudoku_game_checker.sv
// Self-checking bench: a behavioural board RAM plus a frame-level reference
// model of the completion checker, driven by directed and random stimulus.
module tb_sudoku_game_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  RamAddr;
  logic [23:0] RamDat;
  logic        gameComplete;

  logic [23:0] mem [4];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_addr = 0;
  int m_grid [4][4];
  bit m_pend = 1'b0;
  bit m_complete = 1'b0;

  always #5 CLK = ~CLK;

  assign RamDat = mem[RamAddr];

  sudoku_game_checker dut (
    .CLK          (CLK),
    .RST          (RST),
    .RamAddr      (RamAddr),
    .RamDat       (RamDat),
    .gameComplete (gameComplete)
  );

  // Board is solved when every row, column and box holds each of 1..4 exactly once.
  function automatic bit solved();
    int cnt [16];
    int v;
    for (int g = 0; g < 12; g++) begin
      for (int d = 0; d < 16; d++) cnt[d] = 0;
      for (int k = 0; k < 4; k++) begin
        if (g < 4)      v = m_grid[g][k];
        else if (g < 8) v = m_grid[k][g-4];
        else            v = m_grid[((g-8)/2)*2 + k/2][((g-8)%2)*2 + k%2];
        cnt[v]++;
      end
      for (int d = 1; d <= 4; d++) if (cnt[d] != 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance one clock edge and update the model from the values seen at that edge.
  task automatic step();
    @(posedge CLK);
    if (RST) begin
      m_addr = 0;
      m_pend = 1'b0;
      m_complete = 1'b0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_grid[r][c] = 0;
    end else begin
      if (m_pend) m_complete = solved();
      m_pend = (m_addr == 3);
      for (int c = 0; c < 4; c++) m_grid[m_addr][c] = int'((mem[m_addr] >> (12 - 4*c)) & 24'hF);
      m_addr = (m_addr + 1) % 4;
    end
    #1;
  endtask

  task automatic set_all(input logic [23:0] w);
    for (int r = 0; r < 4; r++) mem[r] = w;
  endtask

  task automatic set_solved();
    mem[0] = 24'h001234; mem[1] = 24'h003412; mem[2] = 24'h002143; mem[3] = 24'h004321;
  endtask

  // kind 0: relabelled solved board, 1: relabelled Latin square (boxes fail), 2: random cells
  task automatic load_board(input int kind);
    int p [4];
    int j, t;
    int base [4][4];
    logic [23:0] w;
    for (int i = 0; i < 4; i++) p[i] = i + 1;
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (kind == 0) base[r][c] = (((r % 2) * 2 + (r / 2) + c) % 4);
        else           base[r][c] = (r + c) % 4;
    for (int r = 0; r < 4; r++) begin
      w = 24'(($urandom_range(0, 255)) << 16);
      for (int c = 0; c < 4; c++) begin
        if (kind == 2) t = $urandom_range(0, 5);
        else           t = p[base[r][c]];
        w = w | 24'(t << (12 - 4*c));
      end
      mem[r] = w;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) step();
    n_total++;
    if (RamAddr !== 2'd0) $display("FAIL reset_addr: got %0d expected 0", RamAddr);
    else n_pass++;
    n_total++;
    if (gameComplete !== 1'b0) $display("FAIL reset_complete: got %0b expected 0", gameComplete);
    else n_pass++;
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++;
      if (RamAddr !== 2'((k + 1) % 4)) $display("FAIL scan_addr: got %0d expected %0d", RamAddr, (k + 1) % 4);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_patterns();
    logic [23:0] pats [5];
    pats[0] = 24'h000000; pats[1] = 24'h001111; pats[2] = 24'h001231; pats[3] = 24'h001324;
    pats[4] = 24'h001234;
    for (int p = 0; p < 5; p++) begin
      if (p < 4) set_all(pats[p]);
      else begin
        mem[0] = 24'h001234; mem[1] = 24'h002341; mem[2] = 24'h003412; mem[3] = 24'h004123;
      end
      repeat (8) begin
        step();
        n_total++;
        if (gameComplete !== m_complete) $display("FAIL invalid_model: got %0b expected %0b", gameComplete, m_complete);
        else n_pass++;
      end
      n_total++;
      if (gameComplete !== 1'b0) $display("FAIL invalid_pattern_%0d: got %0b expected 0", p, gameComplete);
      else n_pass++;
    end
  endtask

  task automatic test_solved_latency();
    set_solved();
    RST = 1'b1;
    step();
    RST = 1'b0;
    repeat (4) step();
    n_total++;
    if (gameComplete !== 1'b0) $display("FAIL latency_early: got %0b expected 0", gameComplete);
    else n_pass++;
    step();
    n_total++;
    if (gameComplete !== 1'b1) $display("FAIL latency_solved: got %0b expected 1", gameComplete);
    else n_pass++;
    for (int r = 0; r < 4; r++) mem[r] = mem[r] | 24'hFF0000;
    repeat (8) begin
      step();
      n_total++;
      if (gameComplete !== 1'b1) $display("FAIL flags_ignored: got %0b expected 1", gameComplete);
      else n_pass++;
    end
  endtask

  task automatic test_row_change_and_reset();
    mem[2] = 24'h002134;
    repeat (8) step();
    n_total++;
    if (gameComplete !== 1'b0) $display("FAIL row_change: got %0b expected 0", gameComplete);
    else n_pass++;
    set_solved();
    repeat (8) step();
    n_total++;
    if (gameComplete !== 1'b1) $display("FAIL resolved: got %0b expected 1", gameComplete);
    else n_pass++;
    repeat (2) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_total++;
    if (gameComplete !== 1'b0) $display("FAIL reset_while_set: got %0b expected 0", gameComplete);
    else n_pass++;
    n_total++;
    if (RamAddr !== 2'd0) $display("FAIL reset_while_set_addr: got %0d expected 0", RamAddr);
    else n_pass++;
  endtask

  task automatic test_random();
    load_board(0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      RST = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 11) == 0) load_board($urandom_range(0, 2));
      else if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 3)] = 24'($urandom);
      step();
      n_total++;
      if (gameComplete !== m_complete) $display("FAIL random_complete: cycle %0d got %0b expected %0b", cyc, gameComplete, m_complete);
      else n_pass++;
      n_total++;
      if (RamAddr !== 2'(m_addr)) $display("FAIL random_addr: cycle %0d got %0d expected %0d", cyc, RamAddr, m_addr);
      else n_pass++;
    end
    RST = 1'b0;
  endtask

  initial begin
    set_all(24'h000000);
    test_reset();
    test_invalid_patterns();
    test_solved_latency();
    test_row_change_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
